conv_ctrl: RTL
==============

CONV_CTRL -- requirements
Module: conv_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 8, input feature-map width in pixels.
REQ-002 SHALL have parameter IMG_H, default 8, input feature-map height in pixels.
REQ-003 SHALL have parameter K, default 3, square kernel size; stride 1, no padding; OW=IMG_W-K+1, OH=IMG_H-K+1.
REQ-004 SHALL have parameter IA_W, default 6, ifm_addr width; WA_W, default 4, w_addr width; OA_W, default 6, out_addr width.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port start, input, 1, launch one convolution pass; sampled only in IDLE.
REQ-008 SHALL have port stall, input, 1, datapath backpressure; suppresses issue while high.
REQ-009 SHALL have port busy, output, 1, high in every non-IDLE state.
REQ-010 SHALL have port finish, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port ifm_addr, output, IA_W, input feature-map read address.
REQ-012 SHALL have port w_addr, output, WA_W, weight read address.
REQ-013 SHALL have port mac_en, output, 1, datapath multiply-accumulate enable; read data valid this cycle.
REQ-014 SHALL have port acc_clr, output, 1, with mac_en: load product instead of accumulate.
REQ-015 SHALL have port out_we, output, 1, write accumulator to output memory.
REQ-016 SHALL have port out_addr, output, OA_W, output memory write address, valid with out_we.

Function
REQ-017 SHALL implement FSM IDLE, RUN, DRAIN, DONE: IDLE->RUN on start; RUN->DRAIN after the final issue; DRAIN exactly 2 cycles; DONE exactly 1 cycle; DONE->IDLE.
REQ-018 SHALL keep registered counters kx (fastest), ky, ox, oy (slowest), iterating kx 0..K-1, ky 0..K-1, ox 0..OW-1, oy 0..OH-1.
REQ-019 SHALL define issue = (state==RUN) && !stall; counters advance only on issue.
REQ-020 SHALL drive ifm_addr = (oy+ky)*IMG_W + (ox+kx) and w_addr = ky*K + kx combinationally from the counters, full-precision, never wrapping.
REQ-021 SHALL assert mac_en exactly one cycle after each issue; a stalled cycle becomes a bubble with mac_en=0.
REQ-022 SHALL assert acc_clr together with the mac_en of tap kx=0, ky=0, and at no other time.
REQ-023 SHALL assert out_we two cycles after the issue of tap kx=K-1, ky=K-1, with out_addr = oy*OW + ox of that output.
REQ-024 SHALL make stall ineffective in DRAIN and DONE; in-flight mac_en and out_we always complete.
REQ-025 SHALL ignore start outside IDLE; start held high restarts a new pass in the cycle after DONE.
REQ-026 SHALL, with no stall, raise finish at edge N+2, where edge 0 samples start and N = OH*OW*K*K; busy falls one edge later.
REQ-027 SHALL lengthen the pass by exactly one cycle per RUN cycle with stall high; address order is unchanged.
REQ-028 SHALL be legal only for K<=IMG_W, K<=IMG_H, and widths that fit the maximum addresses.

Reset
REQ-029 SHALL on reset force state IDLE, all counters and pipeline valids 0, busy=finish=mac_en=acc_clr=out_we=0, and ifm_addr=w_addr=out_addr=0.
REQ-030 SHALL let reset override every other input at any time, including mid-pass; no out_we or finish follows reset until a new start.

Verification
REQ-031 Defaults, start pulse, no stall -> 324 mac_en, 36 out_we with out_addr 0..35 in order; first ifm_addr 0,1,2,8,9,10,16,17,18; last ifm_addr 63; finish at edge 326.
REQ-032 Defaults, stall high 5 cycles mid-RUN and on the first RUN cycle -> identical address and out_we sequences; finish delayed 6 cycles; mac_en=0 one cycle after each stalled cycle.
REQ-033 Reset high 1 cycle at edge 100 of a pass -> all outputs 0 on the next cycle; FSM in IDLE; no out_we or finish until the next start.
REQ-034 Start pulsed while busy -> ignored; start held high continuously -> back-to-back passes, busy low for exactly 1 cycle between them.
REQ-035 IMG_W=IMG_H=4, K=1 -> 16 outputs; acc_clr with every mac_en; out_we one cycle after each mac_en; finish at edge 18.

Source files
------------

// File: rtl/conv_ctrl.sv
// conv_ctrl: sequences a stride-1, unpadded KxK convolution over an
// IMG_W x IMG_H feature map. The loop order is kx (fastest), ky, ox, oy.
// It issues read addresses, then one cycle later a MAC enable, and two
// cycles after the final tap of each output it issues an output write.
module conv_ctrl #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int K     = 3,
    parameter int IA_W  = 6,
    parameter int WA_W  = 4,
    parameter int OA_W  = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            stall,
    output logic            busy,
    output logic            finish,
    output logic [IA_W-1:0] ifm_addr,
    output logic [WA_W-1:0] w_addr,
    output logic            mac_en,
    output logic            acc_clr,
    output logic            out_we,
    output logic [OA_W-1:0] out_addr
);

    localparam int OW   = IMG_W - K + 1;
    localparam int OH   = IMG_H - K + 1;
    localparam int MAXD = (IMG_W > IMG_H) ? IMG_W : IMG_H;
    localparam int CW   = $clog2(MAXD) + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]      r_state;
    logic            r_drain_cnt;
    logic [CW-1:0]   r_kx, r_ky, r_ox, r_oy;
    logic            r_mac_en, r_acc_clr, r_we_p, r_out_we;
    logic [OA_W-1:0] r_oaddr_p, r_out_addr;

    logic            w_issue;
    logic            w_kx_last, w_ky_last, w_ox_last, w_oy_last;
    logic            w_tap_last, w_pass_last, w_tap_first;
    logic [CW-1:0]   w_row, w_col;
    logic [OA_W-1:0] w_oaddr;

    assign w_issue     = (r_state == S_RUN) && !stall;
    assign w_kx_last   = (r_kx == CW'(K - 1));
    assign w_ky_last   = (r_ky == CW'(K - 1));
    assign w_ox_last   = (r_ox == CW'(OW - 1));
    assign w_oy_last   = (r_oy == CW'(OH - 1));
    assign w_tap_last  = w_kx_last && w_ky_last;
    assign w_pass_last = w_tap_last && w_ox_last && w_oy_last;
    assign w_tap_first = (r_kx == '0) && (r_ky == '0);

    // Row/column sums never exceed the image bounds, so CW bits suffice.
    assign w_row    = r_oy + r_ky;
    assign w_col    = r_ox + r_kx;
    assign ifm_addr = IA_W'(w_row) * IA_W'(IMG_W) + IA_W'(w_col);
    assign w_addr   = WA_W'(r_ky) * WA_W'(K) + WA_W'(r_kx);
    assign w_oaddr  = OA_W'(r_oy) * OA_W'(OW) + OA_W'(r_ox);

    assign busy     = (r_state != S_IDLE);
    assign finish   = (r_state == S_DONE);
    assign mac_en   = r_mac_en;
    assign acc_clr  = r_acc_clr;
    assign out_we   = r_out_we;
    assign out_addr = r_out_addr;

    // Control FSM: DRAIN holds two cycles so in-flight MAC/write finish before DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_drain_cnt <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE:  if (start) r_state <= S_RUN;
                S_RUN: begin
                    r_drain_cnt <= 1'b0;
                    if (w_issue && w_pass_last) r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    r_drain_cnt <= 1'b1;
                    if (r_drain_cnt) r_state <= S_DONE;
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Nested loop counters; they advance only on issue and wrap to zero after the last tap.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_kx <= '0;
            r_ky <= '0;
            r_ox <= '0;
            r_oy <= '0;
        end else if (w_issue) begin
            if (w_kx_last) begin
                r_kx <= '0;
                if (w_ky_last) begin
                    r_ky <= '0;
                    if (w_ox_last) begin
                        r_ox <= '0;
                        if (w_oy_last) r_oy <= '0;
                        else           r_oy <= r_oy + CW'(1);
                    end else begin
                        r_ox <= r_ox + CW'(1);
                    end
                end else begin
                    r_ky <= r_ky + CW'(1);
                end
            end else begin
                r_kx <= r_kx + CW'(1);
            end
        end
    end

    // Datapath strobes: MAC one cycle after issue, output write two cycles after the final tap.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mac_en   <= 1'b0;
            r_acc_clr  <= 1'b0;
            r_we_p     <= 1'b0;
            r_out_we   <= 1'b0;
            r_oaddr_p  <= '0;
            r_out_addr <= '0;
        end else begin
            r_mac_en   <= w_issue;
            r_acc_clr  <= w_issue && w_tap_first;
            r_we_p     <= w_issue && w_tap_last;
            r_out_we   <= r_we_p;
            if (w_issue && w_tap_last) r_oaddr_p <= w_oaddr;
            r_out_addr <= r_oaddr_p;
        end
    end

endmodule
